vc_demux4_buf: RTL and testbench
================================

Name: vc_demux4_buf

Overview:
- Registered 1-to-4 demultiplexer: the distribution counterpart of the selection muxes.
- Accepts one val/rdy input stream carrying a message, a 2-bit destination select and a 1-bit security domain tag.
- Delivers each accepted message to one of four val/rdy output ports through a one-entry buffer per port.
- Messages tagged secure (domain=1) that are addressed to a non-secure port are consumed and dropped, never forwarded. Every drop is counted and flagged.

Parameters:
- p_nbits, 1, message width in bits
- p_secure_mask, 4'b0001, bit k=1 means output k may receive domain=1 messages
- p_cnt_nbits, 8, width of saturating drop counter

Ports:
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- in_val  input  1  input message valid
- in_rdy  output  1  input ready
- in_msg  input  p_nbits  input message payload
- in_sel  input  2  destination port index 0..3
- in_domain  input  1  security tag, 0=normal, 1=secure
- outK_val  output  1  (K=0..3) port K message valid
- outK_rdy  input  1  (K=0..3) port K consumer ready
- outK_msg  output  p_nbits  (K=0..3) port K payload
- outK_domain  output  1  (K=0..3) tag travelling with port K payload
- drop_count  output  p_cnt_nbits  number of dropped secure messages, saturating
- drop_pulse  output  1  high for exactly one cycle after each drop

Behaviour:
- Reset, asynchronous and active-high:
  - All outK_val=0, outK_msg=0, outK_domain=0.
  - drop_count=0, drop_pulse=0.
  - Takes effect immediately, independent of clk. Buffered messages are discarded, with no partial delivery.
- Per-port state: valid bit, msg register, domain register. The outK_* outputs drive these registers directly, with no combinational path from inputs.
- Output transfer on port K occurs when outK_val & outK_rdy. The valid bit clears next edge unless refilled in the same cycle.
- Drop condition: drop = in_domain & ~p_secure_mask[in_sel].
- in_rdy is combinational from in_sel, in_domain, outK_val and outK_rdy. It must not depend on in_val.
  - If drop: in_rdy=1.
  - Otherwise: in_rdy = ~out[in_sel]_val | out[in_sel]_rdy. A full buffer being drained this cycle may be refilled.
- Accept = in_val & in_rdy.
  - Accept & ~drop: port in_sel loads in_msg and in_domain and sets valid at the next edge. Latency is exactly 1 cycle.
  - Accept & drop: no port state changes. drop_count increments at the next edge, holding at 2^p_cnt_nbits-1. drop_pulse=1 for the following cycle.
- Simultaneous events:
  - Drain and refill of the same port in one cycle: the new message is valid next cycle, giving 1 message/cycle sustained throughput per port.
  - Drains on other ports are independent of input activity.
- Ports not selected hold their contents. msg and domain registers change only on load.
- Head-of-line: the input blocks only on its own selected port. A stall on port K never affects delivery already buffered on other ports.
- in_msg is never visible on any output when drop is true.

Test Plan:
- Reset mid-traffic: fill ports 0–3, assert reset asynchronously between edges -> all outK_val=0 immediately; drop_count=0; first accept after release appears 1 cycle later.
- Basic routing: p_nbits=8; send 0x11/sel0, 0x22/sel1, 0x33/sel2, 0x44/sel3, all domain 0, all outK_rdy=1 -> each appears on the matching port exactly 1 cycle after accept, with outK_domain=0.
- Back-pressure: out2_rdy=0; send 0xA1 then 0xA2 to sel2 -> 0xA1 held on out2; in_rdy=0 for 0xA2. Meanwhile 0xB0/sel1 is accepted and delivered. Raise out2_rdy -> 0xA1 drains and 0xA2 is accepted in the same cycle; 0xA2 valid next cycle.
- Full throughput: out0_rdy=1; stream 0x00..0x0F to sel0 with in_val held high -> in_rdy stays 1; 16 consecutive outputs, one per cycle.
- Security drop: default mask; send 0x5A domain1 sel3 -> in_rdy=1; out3_val stays 0; drop_pulse=1 next cycle; drop_count=1. Then send 0x5B domain1 sel0 -> delivered on out0 with out0_domain=1.
- Counter saturation: p_cnt_nbits=2; 5 consecutive secure drops to sel1 -> drop_count goes 1,2,3,3,3; drop_pulse high on all 5 cycles following the drops.

Source files
------------

// File: rtl/vc_demux4_buf.sv
// vc_demux4_buf: registered 1-to-4 demultiplexer with a one-entry buffer per
// output port. Secure messages addressed to non-secure ports are consumed
// and dropped; each drop is counted (saturating) and flagged for one cycle.
module vc_demux4_buf #(
   parameter int         p_nbits       = 1,
   parameter logic [3:0] p_secure_mask = 4'b0001,
   parameter int         p_cnt_nbits   = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   in_val,
   output logic                   in_rdy,
   input  logic [p_nbits-1:0]     in_msg,
   input  logic [1:0]             in_sel,
   input  logic                   in_domain,
   output logic                   out0_val,
   input  logic                   out0_rdy,
   output logic [p_nbits-1:0]     out0_msg,
   output logic                   out0_domain,
   output logic                   out1_val,
   input  logic                   out1_rdy,
   output logic [p_nbits-1:0]     out1_msg,
   output logic                   out1_domain,
   output logic                   out2_val,
   input  logic                   out2_rdy,
   output logic [p_nbits-1:0]     out2_msg,
   output logic                   out2_domain,
   output logic                   out3_val,
   input  logic                   out3_rdy,
   output logic [p_nbits-1:0]     out3_msg,
   output logic                   out3_domain,
   output logic [p_cnt_nbits-1:0] drop_count,
   output logic                   drop_pulse
);

   localparam logic [p_cnt_nbits-1:0] CNT_ONE = 1;
   localparam logic [p_cnt_nbits-1:0] CNT_MAX = '1;

   logic [3:0]          val_p1;
   logic [p_nbits-1:0]  msg_p1 [4];
   logic [3:0]          dom_p1;
   logic [3:0]          port_rdy;
   logic [3:0]          load_vec;
   logic                drop;
   logic                accept;
   logic [p_cnt_nbits-1:0] cnt_p1;
   logic                pulse_p1;

   // Saturating increment: holds at all-ones instead of wrapping.
   function automatic logic [p_cnt_nbits-1:0] sat_inc(input logic [p_cnt_nbits-1:0] v);
      if (v == CNT_MAX) return v;
      return v + CNT_ONE;
   endfunction

   assign port_rdy = {out3_rdy, out2_rdy, out1_rdy, out0_rdy};

   // Handshake decode: drops are always accepted; otherwise the selected
   // buffer must be empty or draining this cycle. in_val is deliberately
   // kept out of in_rdy.
   always_comb begin
      drop     = in_domain & ~p_secure_mask[in_sel];
      in_rdy   = drop | ~val_p1[in_sel] | port_rdy[in_sel];
      accept   = in_val & in_rdy;
      load_vec = '0;
      if (accept && !drop) load_vec = 4'b0001 << in_sel;
   end

   // ---- stage p1: per-port one-entry buffers (load wins over drain) ----
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         val_p1 <= '0;
         dom_p1 <= '0;
         for (int k = 0; k < 4; k++) msg_p1[k] <= '0;
      end else begin
         for (int k = 0; k < 4; k++) begin
            if (load_vec[k]) begin
               val_p1[k] <= 1'b1;
               msg_p1[k] <= in_msg;
               dom_p1[k] <= in_domain;
            end else if (port_rdy[k]) begin
               val_p1[k] <= 1'b0;
            end
         end
      end
   end

   // Drop accounting: saturating count plus a one-cycle pulse per drop.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_p1   <= '0;
         pulse_p1 <= 1'b0;
      end else begin
         pulse_p1 <= accept & drop;
         if (accept && drop) cnt_p1 <= sat_inc(cnt_p1);
      end
   end

   assign out0_val    = val_p1[0];
   assign out1_val    = val_p1[1];
   assign out2_val    = val_p1[2];
   assign out3_val    = val_p1[3];
   assign out0_msg    = msg_p1[0];
   assign out1_msg    = msg_p1[1];
   assign out2_msg    = msg_p1[2];
   assign out3_msg    = msg_p1[3];
   assign out0_domain = dom_p1[0];
   assign out1_domain = dom_p1[1];
   assign out2_domain = dom_p1[2];
   assign out3_domain = dom_p1[3];
   assign drop_count  = cnt_p1;
   assign drop_pulse  = pulse_p1;

endmodule

// File: tb/tb_vc_demux4_buf.sv
// Bench for vc_demux4_buf: directed scenarios followed by random traffic.
// Accepted messages are queued per port; a negedge monitor pops and checks.
module tb_vc_demux4_buf;

   localparam int NB     = 8;
   localparam int CNT_NB = 2;
   localparam int CNT_MAX = (1 << CNT_NB) - 1;

   logic            clk = 0;
   logic            reset = 1;
   logic            in_val = 0;
   logic            in_rdy;
   logic [NB-1:0]   in_msg = 0;
   logic [1:0]      in_sel = 0;
   logic            in_domain = 0;
   logic [3:0]      out_rdy = 0;
   logic [3:0]      ov;
   logic [3:0]      od;
   logic [NB-1:0]   om [4];
   logic [CNT_NB-1:0] drop_count;
   logic            drop_pulse;

   logic [3:0]      secure_ports = 4'b0001;
   logic [NB:0]     q [4][$];
   int              model_cnt = 0;
   logic            pulse_exp = 0;
   logic            run = 0;
   int              n_checks = 0;
   int              n_fail = 0;

   always #5 clk = ~clk;

   vc_demux4_buf #(
      .p_nbits(NB), .p_secure_mask(4'b0001), .p_cnt_nbits(CNT_NB)
   ) dut (
      .clk(clk), .reset(reset),
      .in_val(in_val), .in_rdy(in_rdy), .in_msg(in_msg),
      .in_sel(in_sel), .in_domain(in_domain),
      .out0_val(ov[0]), .out0_rdy(out_rdy[0]), .out0_msg(om[0]), .out0_domain(od[0]),
      .out1_val(ov[1]), .out1_rdy(out_rdy[1]), .out1_msg(om[1]), .out1_domain(od[1]),
      .out2_val(ov[2]), .out2_rdy(out_rdy[2]), .out2_msg(om[2]), .out2_domain(od[2]),
      .out3_val(ov[3]), .out3_rdy(out_rdy[3]), .out3_msg(om[3]), .out3_domain(od[3]),
      .drop_count(drop_count), .drop_pulse(drop_pulse)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   // Monitor: compares DUT against queue contents and the drop model.
   always @(negedge clk) begin : monitor
      logic ex_rdy;
      if (run && !reset) begin
         ex_rdy = (in_domain & ~secure_ports[in_sel]) | (q[in_sel].size() == 0) | out_rdy[in_sel];
         chk("in_rdy", in_rdy, ex_rdy);
         for (int k = 0; k < 4; k++) begin
            chk($sformatf("out%0d_val", k), ov[k], q[k].size() != 0);
            if (ov[k] && q[k].size() != 0) begin
               chk($sformatf("out%0d_dom_msg", k), {od[k], om[k]}, q[k][0]);
               if (out_rdy[k]) void'(q[k].pop_front());
            end
         end
         chk("drop_count", drop_count, model_cnt);
         chk("drop_pulse", drop_pulse, pulse_exp);
      end
   end

   // One cycle of stimulus, entered and left at posedge+1.
   task automatic step(input logic v, input logic [1:0] s, input logic d,
                       input logic [NB-1:0] m, input logic [3:0] r);
      logic acc, drp;
      in_val = v; in_sel = s; in_domain = d; in_msg = m; out_rdy = r;
      #3;
      drp = d & ~secure_ports[s];
      acc = v & in_rdy;
      @(posedge clk);
      pulse_exp = 0;
      if (acc) begin
         if (drp) begin
            pulse_exp = 1;
            if (model_cnt < CNT_MAX) model_cnt++;
         end else begin
            q[s].push_back({d, m});
         end
      end
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 4'hF);
   endtask

   // Asynchronous reset asserted between clock edges, checked immediately.
   task automatic do_reset();
      in_val = 0;
      #1 reset = 1;
      #1;
      chk("rst_out_val", ov, 0);
      chk("rst_out_domain", od, 0);
      for (int k = 0; k < 4; k++) chk($sformatf("rst_out%0d_msg", k), om[k], 0);
      chk("rst_drop_count", drop_count, 0);
      chk("rst_drop_pulse", drop_pulse, 0);
      for (int k = 0; k < 4; k++) q[k].delete();
      model_cnt = 0;
      pulse_exp = 0;
      run = 1;
      @(posedge clk);
      #3 reset = 0;
      @(posedge clk);
      #1;
   endtask

   initial begin
      do_reset();

      // Basic routing
      step(1, 0, 0, 8'h11, 4'hF);
      step(1, 1, 0, 8'h22, 4'hF);
      step(1, 2, 0, 8'h33, 4'hF);
      step(1, 3, 0, 8'h44, 4'hF);
      idle(2);

      // Back-pressure on port 2 while port 1 keeps flowing
      step(1, 2, 0, 8'hA1, 4'b1011);
      step(1, 2, 0, 8'hA2, 4'b1011);
      step(1, 1, 0, 8'hB0, 4'b1011);
      step(1, 2, 0, 8'hA2, 4'b1011);
      step(1, 2, 0, 8'hA2, 4'hF);
      idle(2);

      // Full throughput on port 0
      for (int i = 0; i < 16; i++) step(1, 0, 0, NB'(i), 4'hF);
      idle(2);

      // Security drop, then a secure message to the secure port
      step(1, 3, 1, 8'h5A, 4'hF);
      step(1, 0, 1, 8'h5B, 4'hF);
      idle(2);

      // Counter saturation
      for (int i = 0; i < 5; i++) step(1, 1, 1, NB'(8'hC0 + i), 4'hF);
      idle(2);

      // Reset mid-traffic with all ports full
      for (int i = 0; i < 4; i++) step(1, 2'(i), 0, NB'(8'h60 + i), 4'h0);
      do_reset();
      step(1, 2, 0, 8'h77, 4'hF);
      idle(2);

      // Random traffic with an intervening reset
      for (int i = 0; i < 600; i++) begin
         if (i == 300) do_reset();
         step($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
              $urandom_range(0, 3) == 0, NB'($urandom),
              4'($urandom) | 4'($urandom));
      end
      idle(4);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
